// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and helpers for the keypad scanner
package keypad_pkg;

  localparam int KP_W = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    RELEASE_WAIT
  } state_t;

  // ASCII legend indexed by {row, col}
  localparam logic [7:0] KEY_MAP [0:15] = '{
    8'h31, 8'h32, 8'h33, 8'h41,
    8'h34, 8'h35, 8'h36, 8'h42,
    8'h37, 8'h38, 8'h39, 8'h43,
    8'h2A, 8'h30, 8'h23, 8'h44
  };

  function automatic logic [1:0] low_row(input logic [KP_W-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KP_W - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [KP_W-1:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/row_sync.sv
// rtl/row_sync.sv - two-flop synchronizer for the asynchronous row lines
module row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  // Idle keypad reads all-ones, so reset to that level to avoid a false press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= '1;
      synced <= '1;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with debounce and ready/valid key output
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = 100000,
  parameter int unsigned DEBOUNCE_CYC = 2000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KP_W-1:0] row_in,
  output logic [KP_W-1:0] col_out,
  output logic [7:0]      key_data,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_drop
);

  localparam logic [31:0] SETTLE_TC = (SETTLE_CYC > 0) ? 32'(SETTLE_CYC - 1) : 32'd0;
  localparam logic [31:0] DEB_TC    = (DEBOUNCE_CYC > 0) ? 32'(DEBOUNCE_CYC - 1) : 32'd0;

  logic [KP_W-1:0] rows;
  state_t          state;
  logic [1:0]      col_idx;
  logic [1:0]      row_idx;
  logic [31:0]     cnt;

  row_sync #(.WIDTH(KP_W)) u_row_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (row_in),
    .synced (rows)
  );

  // cnt holds the number of qualifying cycles already seen in the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col_out   <= 4'b1110;
      row_idx   <= 2'd0;
      cnt       <= 32'd0;
      key_data  <= 8'h00;
      key_valid <= 1'b0;
      key_drop  <= 1'b0;
    end else begin
      key_drop <= 1'b0;
      if (key_valid && key_ready) key_valid <= 1'b0;

      case (state)
        SCAN: begin
          if (cnt >= SETTLE_TC) begin
            cnt <= 32'd0;
            if (rows != '1) begin
              row_idx <= low_row(rows);
              state   <= DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
              col_out <= col_drive(col_idx + 2'd1);
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        DEBOUNCE: begin
          if (rows[row_idx]) begin
            cnt     <= 32'd0;
            col_idx <= col_idx + 2'd1;
            col_out <= col_drive(col_idx + 2'd1);
            state   <= SCAN;
          end else if (cnt >= DEB_TC) begin
            cnt   <= 32'd0;
            state <= EMIT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        EMIT: begin
          // A free slot, or one being drained this cycle, takes the new key
          if (!key_valid || key_ready) begin
            key_data  <= KEY_MAP[{row_idx, col_idx}];
            key_valid <= 1'b1;
          end else begin
            key_drop <= 1'b1;
          end
          cnt   <= 32'd0;
          state <= RELEASE_WAIT;
        end

        RELEASE_WAIT: begin
          if (rows != '1) begin
            cnt <= 32'd0;
          end else if (cnt >= DEB_TC) begin
            cnt     <= 32'd0;
            col_idx <= col_idx + 2'd1;
            col_out <= col_drive(col_idx + 2'd1);
            state   <= SCAN;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: begin
          cnt     <= 32'd0;
          col_idx <= 2'd0;
          col_out <= 4'b1110;
          state   <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized keypad bench with key-sequence scoreboard
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_drop;

  logic [15:0] held = 16'h0;
  string       legend = "123A456B789C*0#D";

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_drop = 0;
  int n_xfer = 0;
  logic [7:0] expq[$];

  keypad_scanner #(.SETTLE_CYC(4), .DEBOUNCE_CYC(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_data  (key_data),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_drop  (key_drop)
  );

  always #5 clk = ~clk;

  // Physical matrix: a closed switch pulls its row low while its column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ascii(input int r, input int c);
    return legend[r*4+c];
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tap(input int r, input int c, input int hold, input int gap);
    held[r*4+c] = 1'b1;
    cyc(hold);
    held[r*4+c] = 1'b0;
    cyc(gap);
  endtask

  // Monitor: column walk, handshake stability, transfers against the expected key order
  initial begin
    logic [3:0] prev_col;
    logic       prev_hold;
    logic [7:0] prev_data;
    prev_col  = 4'hE;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_col  = 4'hE;
        prev_hold = 1'b0;
      end else begin
        if (col_out != prev_col) begin
          check("col_walk", 32'(col_out), 32'({prev_col[2:0], prev_col[3]}));
          prev_col = col_out;
        end
        if (prev_hold) begin
          check("hold_valid", 32'(key_valid), 32'd1);
          check("hold_data", 32'(key_data), 32'(prev_data));
        end
        if (key_valid) n_valid++;
        if (key_drop) n_drop++;
        if (key_valid && key_ready) begin
          n_xfer++;
          if (expq.size() == 0) check("xfer_extra", 32'd1, 32'd0);
          else check("xfer_data", 32'(key_data), 32'(expq.pop_front()));
        end
        prev_hold = key_valid && !key_ready;
        prev_data = key_data;
      end
    end
  end

  initial begin
    int base_v, base_d, base_x, r, c;

    cyc(3);
    check("rst_col", 32'(col_out), 32'hE);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_data", 32'(key_data), 32'h00);
    check("rst_drop", 32'(key_drop), 32'd0);
    rst = 1'b0;
    key_ready = 1'b1;
    cyc(10);

    // Steady press of '6' emits once, nothing more until re-pressed
    base_v = n_valid;
    expq.push_back(ascii(1, 2));
    held[1*4+2] = 1'b1;
    cyc(200);
    check("steady_one_valid", 32'(n_valid - base_v), 32'd1);
    held[1*4+2] = 1'b0;
    cyc(80);
    check("no_repeat", 32'(n_valid - base_v), 32'd1);
    expq.push_back(ascii(1, 2));
    tap(1, 2, 60, 80);
    check("repress_valid", 32'(n_valid - base_v), 32'd2);

    // Bouncing '1' then steady
    base_v = n_valid;
    expq.push_back(ascii(0, 0));
    for (int i = 0; i < 10; i++) begin
      held[0] = ~held[0];
      cyc(3);
    end
    tap(0, 0, 60, 80);
    check("bounce_one_valid", 32'(n_valid - base_v), 32'd1);

    // Backpressure: '1' held in the slot, 'D' dropped
    key_ready = 1'b0;
    base_d = n_drop;
    base_x = n_xfer;
    expq.push_back(ascii(0, 0));
    tap(0, 0, 60, 70);
    tap(3, 3, 60, 70);
    check("bp_valid", 32'(key_valid), 32'd1);
    check("bp_data", 32'(key_data), 32'h31);
    check("bp_drop_count", 32'(n_drop - base_d), 32'd1);
    key_ready = 1'b1;
    cyc(3);
    check("bp_drained", 32'(key_valid), 32'd0);
    check("bp_one_xfer", 32'(n_xfer - base_x), 32'd1);

    // Two rows on column 3: lowest row wins
    expq.push_back(8'h41);
    held[0*4+3] = 1'b1;
    held[2*4+3] = 1'b1;
    cyc(60);
    held = 16'h0;
    cyc(80);

    // Reset in the middle of debounce abandons the press
    rst = 1'b1;
    cyc(3);
    held[1*4+1] = 1'b1;
    rst = 1'b0;
    base_v = n_valid;
    cyc(12);
    check("mid_no_valid_yet", 32'(key_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_col", 32'(col_out), 32'hE);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_data", 32'(key_data), 32'h00);
    check("mid_rst_drop", 32'(key_drop), 32'd0);
    cyc(3);
    held = 16'h0;
    rst = 1'b0;
    cyc(80);
    check("mid_no_emit", 32'(n_valid - base_v), 32'd0);
    expq.push_back(ascii(1, 1));
    tap(1, 1, 60, 80);
    check("mid_repress", 32'(n_valid - base_v), 32'd1);

    // Ordered pair 'C' then '*'
    expq.push_back(8'h43);
    tap(2, 3, 60, 80);
    expq.push_back(8'h2A);
    tap(3, 0, 60, 80);

    // Random keys with random backpressure while held, drained during release
    for (int k = 0; k < 12; k++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      expq.push_back(ascii(r, c));
      for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
        held[r*4+c] = ~held[r*4+c];
        cyc(int'($urandom_range(1, 3)));
      end
      held[r*4+c] = 1'b1;
      for (int t = 0; t < 60 + int'($urandom_range(0, 20)); t++) begin
        key_ready = 1'($urandom_range(0, 1));
        cyc(1);
      end
      held = 16'h0;
      key_ready = 1'b1;
      cyc(70 + int'($urandom_range(0, 20)));
    end

    check("queue_empty", 32'(expq.size()), 32'd0);
    check("total_drops", 32'(n_drop), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
